// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit memory controller.
// FSM state encoding, RV32 access-size codes and unshifted lane masks.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } lsu_state_t;

   localparam logic [1:0] SZ_B   = 2'b00;
   localparam logic [1:0] SZ_H   = 2'b01;
   localparam logic [1:0] SZ_W   = 2'b10;
   localparam logic [1:0] SZ_ILL = 2'b11;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   // Unshifted lane mask for an access size; the illegal code selects no lanes.
   function automatic logic [3:0] size_mask(input logic [1:0] size);
      case (size)
         SZ_B:    size_mask = MASK_B;
         SZ_H:    size_mask = MASK_H;
         SZ_W:    size_mask = MASK_W;
         default: size_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane_align.sv
// Combinational lane steering: byte enables, store-data replication and
// right-alignment of the returned load word.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic [31:0] st_data,
   input  logic [31:0] ld_word,
   output logic [3:0]  be,
   output logic [31:0] st_lanes,
   output logic [31:0] ld_data
);

   always_comb begin
      be = size_mask(size) << offset;
      case (size)
         SZ_B:    st_lanes = {4{st_data[7:0]}};
         SZ_H:    st_lanes = {2{st_data[15:0]}};
         default: st_lanes = st_data;
      endcase
      ld_data = ld_word >> {offset, 3'b000};
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store memory controller with stall timeout.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TMO_CYC = 255
)(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   input  logic [2:0]        i_funct3,
   input  logic              i_we,
   output logic              o_rsp_valid,
   output logic [31:0]       o_rdata,
   output logic [3:0]        o_mask,
   output logic              o_unsign,
   output logic              o_err,
   output logic              o_mem_valid,
   input  logic              i_mem_ready,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_we,
   output logic [3:0]        o_mem_be,
   output logic [31:0]       o_mem_wdata,
   input  logic              i_mem_rvalid,
   input  logic [31:0]       i_mem_rdata
);

   localparam int              CNT_W    = $clog2(TMO_CYC + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

   lsu_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [1:0]        size_q;
   logic              we_q;
   logic              bad_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       rdata_q;
   logic              err_q;
   logic [3:0]        mask_q;
   logic              unsign_q;

   logic              accept;
   logic              tmo_hit;
   logic              mem_go;
   logic [1:0]        req_size;
   logic [1:0]        req_off;
   logic              req_bad;
   logic [3:0]        lane_be;
   logic [31:0]       st_lanes;
   logic [31:0]       ld_data;

   assign accept  = i_req_valid && (state_q == ST_IDLE);
   assign tmo_hit = (cnt_q == TMO_LAST);

   // Request decode: a bad request never reaches memory but still gets a response.
   always_comb begin
      req_size = i_funct3[1:0];
      req_off  = i_addr[1:0];
`ifdef MISALIGN_TRAP_EN
      req_bad  = (req_size == SZ_ILL)
              || ((req_size == SZ_H) && i_addr[0])
              || ((req_size == SZ_W) && (i_addr[1:0] != 2'b00));
`else
      req_bad  = (req_size == SZ_ILL);
      if (req_size == SZ_H) begin
         req_off[0] = 1'b0;
      end else if (req_size == SZ_W) begin
         req_off = 2'b00;
      end
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bad_q) begin
               state_d = ST_RESP;
            end else if (i_mem_ready) begin
               state_d = we_q ? ST_RESP : ST_WAIT;
            end else if (tmo_hit) begin
               state_d = ST_RESP;
            end
         end
         ST_WAIT: begin
            if (i_mem_rvalid || tmo_hit) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_go      = (state_q == ST_ISSUE) && !bad_q;
      o_req_ready = (state_q == ST_IDLE);
      o_rsp_valid = (state_q == ST_RESP);
      o_mem_valid = mem_go;
      o_mem_be    = mem_go ? lane_be : 4'b0000;
      o_mem_we    = mem_go && we_q;
   end

   // Request latch plus response build-up; the stall counter spans ISSUE and WAIT together.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         size_q   <= SZ_B;
         we_q     <= 1'b0;
         bad_q    <= 1'b0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         mask_q   <= '0;
         unsign_q <= 1'b0;
      end else if (accept) begin
         addr_q   <= {i_addr[ADDR_W-1:2], req_off};
         wdata_q  <= i_wdata;
         size_q   <= req_size;
         we_q     <= i_we;
         bad_q    <= req_bad;
         cnt_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         mask_q   <= size_mask(req_size);
         unsign_q <= !i_we && i_funct3[2];
      end else begin
         case (state_q)
            ST_ISSUE: begin
               if (bad_q) begin
                  err_q <= 1'b1;
               end else if (!i_mem_ready) begin
                  if (tmo_hit) begin
                     err_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (i_mem_rvalid) begin
                  rdata_q <= ld_data;
               end else if (tmo_hit) begin
                  err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   lsu_lane_align u_lane_align (
      .size     (size_q),
      .offset   (addr_q[1:0]),
      .st_data  (wdata_q),
      .ld_word  (i_mem_rdata),
      .be       (lane_be),
      .st_lanes (st_lanes),
      .ld_data  (ld_data)
   );

   assign o_mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign o_mem_wdata = st_lanes;
   assign o_rdata     = rdata_q;
   assign o_err       = err_q;
   assign o_mask      = mask_q;
   assign o_unsign    = unsign_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized self-checking bench for lsu_mem_ctrl against a cycle-count reference model.
// Honors MISALIGN_TRAP_EN the same way the design does.
module tb_lsu_mem_ctrl;

   localparam int ADDR_W = 32;
   localparam int TMO    = 20;

   logic              i_clk = 1'b0;
   logic              i_rst_n = 1'b0;
   logic              i_req_valid = 1'b0;
   logic              o_req_ready;
   logic [ADDR_W-1:0] i_addr = '0;
   logic [31:0]       i_wdata = '0;
   logic [2:0]        i_funct3 = '0;
   logic              i_we = 1'b0;
   logic              o_rsp_valid;
   logic [31:0]       o_rdata;
   logic [3:0]        o_mask;
   logic              o_unsign;
   logic              o_err;
   logic              o_mem_valid;
   logic              i_mem_ready = 1'b0;
   logic [ADDR_W-1:0] o_mem_addr;
   logic              o_mem_we;
   logic [3:0]        o_mem_be;
   logic [31:0]       o_mem_wdata;
   logic              i_mem_rvalid = 1'b0;
   logic [31:0]       i_mem_rdata = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 i_clk = ~i_clk;

   lsu_mem_ctrl #(.ADDR_W(ADDR_W), .TMO_CYC(TMO)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .i_addr       (i_addr),
      .i_wdata      (i_wdata),
      .i_funct3     (i_funct3),
      .i_we         (i_we),
      .o_rsp_valid  (o_rsp_valid),
      .o_rdata      (o_rdata),
      .o_mask       (o_mask),
      .o_unsign     (o_unsign),
      .o_err        (o_err),
      .o_mem_valid  (o_mem_valid),
      .i_mem_ready  (i_mem_ready),
      .o_mem_addr   (o_mem_addr),
      .o_mem_we     (o_mem_we),
      .o_mem_be     (o_mem_be),
      .o_mem_wdata  (o_mem_wdata),
      .i_mem_rvalid (i_mem_rvalid),
      .i_mem_rdata  (i_mem_rdata)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic checkReset();
      checkOutput("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      checkOutput("rst_mem_valid", 32'(o_mem_valid), 32'd0);
      checkOutput("rst_err",       32'(o_err),       32'd0);
      checkOutput("rst_rdata",     o_rdata,          32'd0);
      checkOutput("rst_mask",      32'(o_mask),      32'd0);
      checkOutput("rst_unsign",    32'(o_unsign),    32'd0);
      checkOutput("rst_mem_be",    32'(o_mem_be),    32'd0);
      checkOutput("rst_mem_we",    32'(o_mem_we),    32'd0);
   endtask

   // One transaction: d = cycles before memory ready, r = WAIT cycles before rvalid.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, input logic we,
                                input int d, input int r, input logic [31:0] word);
      logic [1:0]  size, off;
      logic        illegal, mis, access, timeout;
      logic [3:0]  base, be;
      logic [31:0] wrep, exp_rdata;
      int          stalls, rsp_cyc, valid_last;

      size    = f3[1:0];
      illegal = (size == 2'd3);
      off     = addr[1:0];
      mis     = 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis = ((size == 2'd1) && (off % 2 != 0)) || ((size == 2'd2) && (off != 0));
`else
      if (size == 2'd1) off = (off / 2) * 2;
      if (size == 2'd2) off = 2'd0;
`endif
      access = !illegal && !mis;
      base   = (size == 2'd0) ? 4'd1 : (size == 2'd1) ? 4'd3 : (size == 2'd2) ? 4'd15 : 4'd0;
      be     = 4'((32'(base) << off) & 32'hF);
      wrep   = (size == 2'd0) ? 32'(wdata[7:0]) * 32'h01010101 :
               (size == 2'd1) ? 32'(wdata[15:0]) * 32'h00010001 : wdata;
      if (!access) begin
         timeout    = 1'b0;
         rsp_cyc    = 2;
         valid_last = 0;
      end else begin
         stalls     = we ? d : d + r;
         timeout    = (stalls >= TMO);
         if (timeout) rsp_cyc = (d >= TMO) ? TMO + 1 : TMO + 2;
         else         rsp_cyc = we ? d + 2 : d + r + 3;
         valid_last = (d >= TMO) ? TMO : d + 1;
      end
      exp_rdata = (access && !we && !timeout) ? (word >> (8 * off)) : 32'd0;

      @(negedge i_clk);
      checkOutput("req_ready_idle", 32'(o_req_ready), 32'd1);
      i_req_valid  = 1'b1;
      i_addr       = addr;
      i_wdata      = wdata;
      i_funct3     = f3;
      i_we         = we;
      i_mem_ready  = 1'b0;
      i_mem_rvalid = 1'b0;

      for (int n = 1; n <= rsp_cyc + 1; n++) begin
         @(negedge i_clk);
         checkOutput("rsp_valid", 32'(o_rsp_valid), 32'(n == rsp_cyc));
         checkOutput("mem_valid", 32'(o_mem_valid), 32'(access && (n <= valid_last)));
         if (access && (n <= valid_last)) begin
            checkOutput("mem_addr", o_mem_addr, {addr[31:2], 2'b00});
            checkOutput("mem_be",   32'(o_mem_be), 32'(be));
            checkOutput("mem_we",   32'(o_mem_we), 32'(we));
            if (we) checkOutput("mem_wdata", o_mem_wdata, wrep);
         end
         if (n == rsp_cyc) begin
            checkOutput("rsp_err",   32'(o_err), 32'(!access || timeout));
            checkOutput("rsp_rdata", o_rdata,    exp_rdata);
            if (!we && !illegal) begin
               checkOutput("rsp_mask",   32'(o_mask),   32'(base));
               checkOutput("rsp_unsign", 32'(o_unsign), 32'(f3[2]));
            end
         end
         if (n == rsp_cyc + 1) checkOutput("req_ready_after", 32'(o_req_ready), 32'd1);

         i_req_valid = (n < rsp_cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
         i_addr      = $urandom;
         i_wdata     = $urandom;
         i_funct3    = 3'($urandom);
         i_we        = 1'($urandom);
         i_mem_ready = (n >= d + 1);
         if (!we && (n == d + 2 + r)) begin
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = word;
         end else begin
            i_mem_rvalid = (n <= d + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_mem_rdata  = $urandom;
         end
      end
      i_mem_ready  = 1'b0;
      i_mem_rvalid = 1'b0;
   endtask

   initial begin
      int d, r;

      repeat (3) @(negedge i_clk);
      checkReset();
      checkOutput("rst_req_ready", 32'(o_req_ready), 32'd1);
      i_rst_n = 1'b1;

      applyStimulus(32'h0000_1003, 32'h0,         3'b000, 1'b0, 0, 0, 32'hAABBCCDD);
      applyStimulus(32'h0000_2002, 32'h0000_1234, 3'b001, 1'b1, 0, 0, 32'h0);
      applyStimulus(32'h0000_3000, 32'h0,         3'b010, 1'b0, 4, 0, 32'h1234_5678);
      applyStimulus(32'h0000_4001, 32'h0,         3'b010, 1'b0, 0, 0, 32'hCAFE_F00D);
      applyStimulus(32'h0000_5002, 32'h0,         3'b101, 1'b0, 0, 0, 32'h8765_4321);
      applyStimulus(32'h0000_6000, 32'h0,         3'b011, 1'b0, 0, 0, 32'h0);
      applyStimulus(32'h0000_7000, 32'h0,         3'b010, 1'b0, 0, 1000, 32'h0);
      applyStimulus(32'h0000_7004, 32'h0,         3'b010, 1'b0, 1, 2, 32'h0BAD_BEEF);
      applyStimulus(32'h0000_8000, 32'h5555_AAAA, 3'b010, 1'b1, TMO + 3, 0, 32'h0);
      applyStimulus(32'h0000_8001, 32'h0000_00A5, 3'b000, 1'b1, 2, 0, 32'h0);

      for (int k = 0; k < 40; k++) begin
         d = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 3);
         r = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 4, TMO + 2) : $urandom_range(0, 3);
         applyStimulus($urandom, $urandom, 3'($urandom), 1'($urandom), d, r, $urandom);
      end

      // Reset while a load sits in WAIT, followed by a late memory return.
      @(negedge i_clk);
      i_req_valid = 1'b1;
      i_addr      = 32'h0000_9000;
      i_funct3    = 3'b010;
      i_we        = 1'b0;
      @(negedge i_clk);
      i_req_valid = 1'b0;
      i_mem_ready = 1'b1;
      @(negedge i_clk);
      i_mem_ready = 1'b0;
      checkOutput("wait_no_mem_valid", 32'(o_mem_valid), 32'd0);
      i_rst_n = 1'b0;
      #1;
      checkReset();
      @(negedge i_clk);
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'hDEAD_BEEF;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         checkOutput("post_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
         checkOutput("post_rst_req_ready", 32'(o_req_ready), 32'd1);
         checkOutput("post_rst_rdata",     o_rdata,          32'd0);
      end
      i_mem_rvalid = 1'b0;

      applyStimulus(32'h0000_A00C, 32'h0, 3'b010, 1'b0, 0, 0, 32'h1357_9BDF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
